multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle successor to the single-cycle MIPS decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. It handshakes with a variable-latency memory and a syscall handler, and drives the same 11-bit packed control vector to the datapath one phase at a time. It sits between the instruction/data memory port and the existing register-file/ALU datapath. Added behaviour: memory wait states with timeout, a syscall stall, a sticky fault on illegal opcodes, and a retired-instruction counter.

## Interface
- TIMEOUT, 16: consecutive not-ready memory cycles before fault; 0 disables the timeout.
- RETIRE_W, 32: width of the retired-instruction counter.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_rdata  in  32  memory read data; captured into the internal IR on fetch completion.
- mem_ready  in  1  memory completes the current request this cycle.
- alu_zero  in  1  ALU zero flag, sampled in EXEC.
- syscall_done  in  1  handler finished.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write qualifier for mem_req.
- ir_write  out  1  IR capture pulse.
- pc_write  out  1  PC update pulse.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = register (JR).
- reg_write  out  1  register-file write strobe.
- syscall_req  out  1  held while the syscall is pending.
- controlSignals  out  11  {RegDst, Jump, Branch, MemRead, MemToReg, ALUop[2:0], RegWrite, ALUsrc, MemWrite}; same encodings as the single-cycle decoder.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, SYSCALL=5, FAULT=7.
- fault  out  1  sticky illegal-instruction or timeout flag.
- retired  out  RETIRE_W  count of completed instructions; wraps.

## Operation
- **FETCH**
  - mem_req=1, mem_we=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- **DECODE**
  - Classify the IR opcode/function fields using the header macros.
  - All-zero word (NOP): retire, then go to FETCH.
  - SYSCALL: go to SYSCALL.
  - Unlisted opcode or function: go to FAULT.
  - Otherwise: go to EXEC.
- **EXEC**
  - controlSignals drives the decoded vector.
  - BEQ: pc_write=alu_zero, pc_src=1, retire, go to FETCH.
  - BNE: pc_write=!alu_zero, pc_src=1, retire, go to FETCH.
  - J: pc_write=1, pc_src=2, retire, go to FETCH.
  - JAL: as J, plus reg_write=1 in the same cycle.
  - JR: pc_write=1, pc_src=3, retire, go to FETCH (no register write).
  - LW/SW: go to MEM.
  - R-type ALU ops, ADDI, ADDIU, ORI, LUI: go to WB.
- **MEM**
  - mem_req=1; mem_we=1 for SW only.
  - On mem_ready: LW goes to WB; SW retires and goes to FETCH.
- **WB**: reg_write=1, retire, go to FETCH.
- **SYSCALL**
  - syscall_req=1 until syscall_done.
  - On the syscall_done cycle: reg_write=1, retire, go to FETCH.
- **FAULT**
  - fault=1; all strobes 0.
  - Exit only on reset.
- **controlSignals**: 0 in FETCH, DECODE, SYSCALL and FAULT; otherwise the IR decode, held through EXEC/MEM/WB.
- **Retire**: retired increments by 1 on each retire event, modulo 2^RETIRE_W.
- **Wait counter**
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0, go to FAULT.
  - mem_ready=1 on that same cycle wins: normal completion.

## Timing
- Outputs are a Moore decode of state + IR. The only exceptions, which also depend on inputs in the same cycle:
  - ir_write and pc_write in FETCH (on mem_ready).
  - pc_write in EXEC (branch decision).
  - reg_write in SYSCALL (on syscall_done).
- Reset:
  - While reset is asserted, all outputs are 0, including retired and fault.
  - The first cycle after deassertion is FETCH with mem_req=1.
  - Reset mid-instruction aborts immediately: IR, wait counter and fault clear, and no retire occurs.
- Latency with zero-wait memory (mem_ready in the request's first cycle):
  - branch/jump: 3 cycles
  - ALU/immediate: 4 cycles
  - SW: 4 cycles
  - LW: 5 cycles
  - NOP: 2 cycles
  - Each memory wait cycle adds 1.
- mem_req stays high with a stable mem_we from the first request cycle through the mem_ready cycle; it deasserts the cycle after.
- syscall_done while not in SYSCALL is ignored.
- mem_ready outside FETCH/MEM is ignored.

## Test plan
- **ADD, zero-wait**: state sequence 0,1,2,4,0; reg_write=1 only in WB; controlSignals in EXEC = 11'b10000010100; retired 0→1.
- **LW, 3-wait data memory**: MEM lasts 4 cycles with mem_req held and mem_we=0; WB has MemToReg=1; total 8 cycles; retired +1.
- **BEQ alu_zero=0 then BNE alu_zero=0**: BEQ gives pc_write=0; BNE gives pc_write=1 with pc_src=1; each takes 3 cycles; retired +2.
- **Timeout, TIMEOUT=4, mem_ready held 0 in FETCH**: fault=1 and state=7 after the 4th wait cycle; stays sticky for 20 cycles; reset clears it and returns to FETCH.
- **Illegal opcode 6'b111111**: goes to FAULT from DECODE; no reg_write, pc_write or retire.
- **SYSCALL with syscall_done after 5 cycles**: syscall_req high for 5 cycles; reg_write pulses on the done cycle; reset asserted mid-SYSCALL in a repeat run gives retired=0 and syscall_req=0 the next cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/writeback, handshakes with a
// variable-latency memory and a syscall handler, and traps illegal opcodes or memory timeouts.
module multicycle_control #(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [31:0]         i_mem_rdata,
    input  logic                i_mem_ready,
    input  logic                i_alu_zero,
    input  logic                i_syscall_done,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic                o_ir_write,
    output logic                o_pc_write,
    output logic [1:0]          o_pc_src,
    output logic                o_reg_write,
    output logic                o_syscall_req,
    output logic [10:0]         o_control_signals,
    output logic [2:0]          o_state,
    output logic                o_fault,
    output logic [RETIRE_W-1:0] o_retired
);

    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [5:0] FnSll     = 6'h00;
    localparam logic [5:0] FnSrl     = 6'h02;
    localparam logic [5:0] FnSra     = 6'h03;
    localparam logic [5:0] FnJr      = 6'h08;
    localparam logic [5:0] FnSyscall = 6'h0c;
    localparam logic [5:0] FnAdd     = 6'h20;
    localparam logic [5:0] FnAddu    = 6'h21;
    localparam logic [5:0] FnSub     = 6'h22;
    localparam logic [5:0] FnSubu    = 6'h23;
    localparam logic [5:0] FnAnd     = 6'h24;
    localparam logic [5:0] FnOr      = 6'h25;
    localparam logic [5:0] FnXor     = 6'h26;
    localparam logic [5:0] FnNor     = 6'h27;
    localparam logic [5:0] FnSlt     = 6'h2a;
    localparam logic [5:0] FnSltu    = 6'h2b;

    // {RegDst, Jump, Branch, MemRead, MemToReg, ALUop[2:0], RegWrite, ALUsrc, MemWrite}
    localparam logic [10:0] CtrlRtype  = 11'b10000010100;
    localparam logic [10:0] CtrlLw     = 11'b00011000110;
    localparam logic [10:0] CtrlSw     = 11'b00000000011;
    localparam logic [10:0] CtrlBranch = 11'b00100001000;
    localparam logic [10:0] CtrlJ      = 11'b01000000000;
    localparam logic [10:0] CtrlJal    = 11'b01000000100;
    localparam logic [10:0] CtrlJr     = 11'b01000000000;
    localparam logic [10:0] CtrlAddi   = 11'b00000000110;
    localparam logic [10:0] CtrlOri    = 11'b00000011110;
    localparam logic [10:0] CtrlLui    = 11'b00000100110;

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExec    = 3'd2,
        StMem     = 3'd3,
        StWb      = 3'd4,
        StSyscall = 3'd5,
        StFault   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        ClsAlu, ClsLw, ClsSw, ClsBeq, ClsBne, ClsJ, ClsJal, ClsJr
    } cls_t;

    state_t              r_state;
    logic [31:0]         r_ir;
    logic [WaitW-1:0]    r_wait;
    cls_t                r_cls;
    logic [10:0]         r_ctrl;
    logic [RETIRE_W-1:0] r_retired;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_nop;
    logic        w_sys;
    logic        w_legal;
    cls_t        w_cls;
    logic [10:0] w_ctrl;
    logic        w_timeout;
    logic        w_retire;

    assign w_op      = r_ir[31:26];
    assign w_funct   = r_ir[5:0];
    assign w_timeout = (TIMEOUT != 0) && (r_wait == WaitW'(TIMEOUT - 1));

    always_comb begin
        w_nop   = 1'b0;
        w_sys   = 1'b0;
        w_legal = 1'b1;
        w_cls   = ClsAlu;
        w_ctrl  = '0;
        if (r_ir == 32'h0) begin
            w_nop = 1'b1;
        end else begin
            case (w_op)
                OpRtype: begin
                    case (w_funct)
                        FnSll, FnSrl, FnSra, FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr,
                        FnXor, FnNor, FnSlt, FnSltu: w_ctrl = CtrlRtype;
                        FnJr: begin
                            w_cls  = ClsJr;
                            w_ctrl = CtrlJr;
                        end
                        FnSyscall: w_sys = 1'b1;
                        default:   w_legal = 1'b0;
                    endcase
                end
                OpJ: begin
                    w_cls  = ClsJ;
                    w_ctrl = CtrlJ;
                end
                OpJal: begin
                    w_cls  = ClsJal;
                    w_ctrl = CtrlJal;
                end
                OpBeq: begin
                    w_cls  = ClsBeq;
                    w_ctrl = CtrlBranch;
                end
                OpBne: begin
                    w_cls  = ClsBne;
                    w_ctrl = CtrlBranch;
                end
                OpAddi, OpAddiu: w_ctrl = CtrlAddi;
                OpOri:           w_ctrl = CtrlOri;
                OpLui:           w_ctrl = CtrlLui;
                OpLw: begin
                    w_cls  = ClsLw;
                    w_ctrl = CtrlLw;
                end
                OpSw: begin
                    w_cls  = ClsSw;
                    w_ctrl = CtrlSw;
                end
                default: w_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            StDecode:  w_retire = w_nop;
            StExec:    w_retire = (r_cls != ClsAlu) && (r_cls != ClsLw) && (r_cls != ClsSw);
            StMem:     w_retire = i_mem_ready && (r_cls == ClsSw);
            StWb:      w_retire = 1'b1;
            StSyscall: w_retire = i_syscall_done;
            default:   w_retire = 1'b0;
        endcase
    end

    // The wait counter only moves in FETCH/MEM and is zeroed on every exit, so it is
    // always zero on entry to either state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StFetch;
            r_ir      <= '0;
            r_wait    <= '0;
            r_cls     <= ClsAlu;
            r_ctrl    <= '0;
            r_retired <= '0;
        end else begin
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
            case (r_state)
                StFetch: begin
                    if (i_mem_ready) begin
                        r_ir    <= i_mem_rdata;
                        r_wait  <= '0;
                        r_state <= StDecode;
                    end else if (w_timeout) begin
                        r_wait  <= '0;
                        r_state <= StFault;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                StDecode: begin
                    if (w_nop) begin
                        r_state <= StFetch;
                    end else if (w_sys) begin
                        r_state <= StSyscall;
                    end else if (!w_legal) begin
                        r_state <= StFault;
                    end else begin
                        r_cls   <= w_cls;
                        r_ctrl  <= w_ctrl;
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    case (r_cls)
                        ClsLw, ClsSw: r_state <= StMem;
                        ClsAlu:       r_state <= StWb;
                        default:      r_state <= StFetch;
                    endcase
                end
                StMem: begin
                    if (i_mem_ready) begin
                        r_wait  <= '0;
                        r_state <= (r_cls == ClsLw) ? StWb : StFetch;
                    end else if (w_timeout) begin
                        r_wait  <= '0;
                        r_state <= StFault;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                StWb: r_state <= StFetch;
                StSyscall: begin
                    if (i_syscall_done) begin
                        r_state <= StFetch;
                    end
                end
                StFault: r_state <= StFault;
                default: r_state <= StFault;
            endcase
        end
    end

    always_comb begin
        o_mem_req         = 1'b0;
        o_mem_we          = 1'b0;
        o_ir_write        = 1'b0;
        o_pc_write        = 1'b0;
        o_pc_src          = 2'd0;
        o_reg_write       = 1'b0;
        o_syscall_req     = 1'b0;
        o_control_signals = '0;
        o_state           = r_state;
        o_fault           = 1'b0;
        o_retired         = r_retired;
        case (r_state)
            StFetch: begin
                o_mem_req  = 1'b1;
                o_ir_write = i_mem_ready;
                o_pc_write = i_mem_ready;
            end
            StExec: begin
                o_control_signals = r_ctrl;
                case (r_cls)
                    ClsBeq: begin
                        o_pc_write = i_alu_zero;
                        o_pc_src   = 2'd1;
                    end
                    ClsBne: begin
                        o_pc_write = !i_alu_zero;
                        o_pc_src   = 2'd1;
                    end
                    ClsJ: begin
                        o_pc_write = 1'b1;
                        o_pc_src   = 2'd2;
                    end
                    ClsJal: begin
                        o_pc_write  = 1'b1;
                        o_pc_src    = 2'd2;
                        o_reg_write = 1'b1;
                    end
                    ClsJr: begin
                        o_pc_write = 1'b1;
                        o_pc_src   = 2'd3;
                    end
                    default: o_pc_write = 1'b0;
                endcase
            end
            StMem: begin
                o_control_signals = r_ctrl;
                o_mem_req         = 1'b1;
                o_mem_we          = (r_cls == ClsSw);
            end
            StWb: begin
                o_control_signals = r_ctrl;
                o_reg_write       = 1'b1;
            end
            StSyscall: begin
                o_syscall_req = 1'b1;
                o_reg_write   = i_syscall_done;
            end
            StFault: o_fault = 1'b1;
            default: o_fault = 1'b0;
        endcase
        // Reset is synchronous, so mask outputs combinationally to keep them quiet while held.
        if (i_reset) begin
            o_mem_req         = 1'b0;
            o_mem_we          = 1'b0;
            o_ir_write        = 1'b0;
            o_pc_write        = 1'b0;
            o_pc_src          = 2'd0;
            o_reg_write       = 1'b0;
            o_syscall_req     = 1'b0;
            o_control_signals = '0;
            o_state           = 3'd0;
            o_fault           = 1'b0;
            o_retired         = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle stimulus with hand-derived expectations.
module tb_multicycle_control;

    localparam logic [31:0] IAdd  = 32'h0022_1820;
    localparam logic [31:0] ILw   = 32'h8C22_0004;
    localparam logic [31:0] ISw   = 32'hAC22_0004;
    localparam logic [31:0] IBeq  = 32'h1022_0003;
    localparam logic [31:0] IBne  = 32'h1422_0003;
    localparam logic [31:0] IJ    = 32'h0800_0010;
    localparam logic [31:0] IJal  = 32'h0C00_0010;
    localparam logic [31:0] IJr   = 32'h0020_0008;
    localparam logic [31:0] INop  = 32'h0000_0000;
    localparam logic [31:0] ISys  = 32'h0000_000C;
    localparam logic [31:0] IIll  = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        alu_zero;
    logic        syscall_done;
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic        syscall_req;
    logic [10:0] ctrl;
    logic [2:0]  state;
    logic        fault;
    logic [31:0] retired;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .TIMEOUT (4),
        .RETIRE_W(32)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_mem_rdata      (mem_rdata),
        .i_mem_ready      (mem_ready),
        .i_alu_zero       (alu_zero),
        .i_syscall_done   (syscall_done),
        .o_mem_req        (mem_req),
        .o_mem_we         (mem_we),
        .o_ir_write       (ir_write),
        .o_pc_write       (pc_write),
        .o_pc_src         (pc_src),
        .o_reg_write      (reg_write),
        .o_syscall_req    (syscall_req),
        .o_control_signals(ctrl),
        .o_state          (state),
        .o_fault          (fault),
        .o_retired        (retired)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic rdy, input logic [31:0] rd, input logic az, input logic sd);
        mem_ready    = rdy;
        mem_rdata    = rd;
        alu_zero     = az;
        syscall_done = sd;
        #1;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch followed by the decode cycle; returns at the start of the cycle after DECODE.
    task automatic fetch_decode(input string tag, input logic [31:0] instr);
        set_in(1'b1, instr, 1'b0, 1'b0);
        check_eq({tag, " fetch state"}, 32'(state), 32'd0);
        check_eq({tag, " fetch ir_write"}, 32'(ir_write), 32'd1);
        next_cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq({tag, " decode state"}, 32'(state), 32'd1);
        next_cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        next_cyc();
        next_cyc();
        check_eq("rst state", 32'(state), 32'd0);
        check_eq("rst mem_req", 32'(mem_req), 32'd0);
        check_eq("rst retired", retired, 32'd0);
        check_eq("rst fault", 32'(fault), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("post-rst mem_req", 32'(mem_req), 32'd1);

        // ADD, zero-wait: 0,1,2,4,0
        set_in(1'b1, IAdd, 1'b0, 1'b0);
        check_eq("add F ir_write", 32'(ir_write), 32'd1);
        check_eq("add F pc_write", 32'(pc_write), 32'd1);
        check_eq("add F pc_src", 32'(pc_src), 32'd0);
        check_eq("add F reg_write", 32'(reg_write), 32'd0);
        next_cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("add D state", 32'(state), 32'd1);
        check_eq("add D ctrl", 32'(ctrl), 32'd0);
        next_cyc();
        check_eq("add E state", 32'(state), 32'd2);
        check_eq("add E ctrl", 32'(ctrl), 32'(11'b10000010100));
        check_eq("add E reg_write", 32'(reg_write), 32'd0);
        next_cyc();
        check_eq("add W state", 32'(state), 32'd4);
        check_eq("add W reg_write", 32'(reg_write), 32'd1);
        next_cyc();
        check_eq("add done state", 32'(state), 32'd0);
        check_eq("add retired", retired, 32'd1);

        // LW with 3 wait cycles in MEM
        fetch_decode("lw", ILw);
        check_eq("lw E ctrl", 32'(ctrl), 32'(11'b00011000110));
        next_cyc();
        for (int i = 0; i < 4; i++) begin
            set_in(i == 3, 32'h0, 1'b0, 1'b0);
            check_eq("lw M state", 32'(state), 32'd3);
            check_eq("lw M mem_req", 32'(mem_req), 32'd1);
            check_eq("lw M mem_we", 32'(mem_we), 32'd0);
            next_cyc();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("lw W state", 32'(state), 32'd4);
        check_eq("lw W memtoreg", 32'(ctrl[6]), 32'd1);
        check_eq("lw W reg_write", 32'(reg_write), 32'd1);
        check_eq("lw W mem_req", 32'(mem_req), 32'd0);
        next_cyc();
        check_eq("lw retired", retired, 32'd2);

        // BEQ: pc_write follows alu_zero combinationally
        fetch_decode("beq", IBeq);
        set_in(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("beq az1 pc_write", 32'(pc_write), 32'd1);
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("beq az0 pc_write", 32'(pc_write), 32'd0);
        check_eq("beq pc_src", 32'(pc_src), 32'd1);
        next_cyc();
        check_eq("beq next state", 32'(state), 32'd0);
        fetch_decode("bne", IBne);
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("bne az0 pc_write", 32'(pc_write), 32'd1);
        check_eq("bne pc_src", 32'(pc_src), 32'd1);
        next_cyc();
        check_eq("branch retired", retired, 32'd4);

        // Jumps
        fetch_decode("j", IJ);
        check_eq("j pc_write", 32'(pc_write), 32'd1);
        check_eq("j pc_src", 32'(pc_src), 32'd2);
        check_eq("j reg_write", 32'(reg_write), 32'd0);
        next_cyc();
        fetch_decode("jal", IJal);
        check_eq("jal pc_src", 32'(pc_src), 32'd2);
        check_eq("jal reg_write", 32'(reg_write), 32'd1);
        next_cyc();
        fetch_decode("jr", IJr);
        check_eq("jr pc_src", 32'(pc_src), 32'd3);
        check_eq("jr reg_write", 32'(reg_write), 32'd0);
        next_cyc();
        check_eq("jump retired", retired, 32'd7);

        // NOP retires from DECODE
        fetch_decode("nop", INop);
        check_eq("nop next state", 32'(state), 32'd0);
        check_eq("nop retired", retired, 32'd8);

        // SW, zero-wait data memory
        fetch_decode("sw", ISw);
        next_cyc();
        set_in(1'b1, 32'h0, 1'b0, 1'b0);
        check_eq("sw M state", 32'(state), 32'd3);
        check_eq("sw M mem_we", 32'(mem_we), 32'd1);
        check_eq("sw M ctrl", 32'(ctrl), 32'(11'b00000000011));
        next_cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("sw next state", 32'(state), 32'd0);
        check_eq("sw retired", retired, 32'd9);

        // SYSCALL, done on 5th cycle
        fetch_decode("sys", ISys);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 32'h0, 1'b0, i == 4);
            check_eq("sys state", 32'(state), 32'd5);
            check_eq("sys syscall_req", 32'(syscall_req), 32'd1);
            check_eq("sys reg_write", 32'(reg_write), (i == 4) ? 32'd1 : 32'd0);
            next_cyc();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("sys next state", 32'(state), 32'd0);
        check_eq("sys retired", retired, 32'd10);

        // mem_ready on the last allowed wait cycle completes normally
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0);
            next_cyc();
        end
        fetch_decode("late", INop);
        check_eq("late retired", retired, 32'd11);

        // Illegal opcode traps from DECODE and is sticky
        fetch_decode("ill", IIll);
        check_eq("ill state", 32'(state), 32'd7);
        check_eq("ill fault", 32'(fault), 32'd1);
        check_eq("ill reg_write", 32'(reg_write), 32'd0);
        check_eq("ill pc_write", 32'(pc_write), 32'd0);
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, IAdd, 1'b1, 1'b1);
            next_cyc();
        end
        check_eq("ill sticky state", 32'(state), 32'd7);
        check_eq("ill sticky mem_req", 32'(mem_req), 32'd0);
        check_eq("ill retired", retired, 32'd11);
        reset = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("ill rst fault", 32'(fault), 32'd0);
        next_cyc();
        reset = 1'b0;
        #1;
        check_eq("ill rst state", 32'(state), 32'd0);
        check_eq("ill rst retired", retired, 32'd0);

        // Fetch timeout after 4 not-ready cycles
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0);
            check_eq("to wait state", 32'(state), 32'd0);
            next_cyc();
        end
        check_eq("to state", 32'(state), 32'd7);
        check_eq("to fault", 32'(fault), 32'd1);
        for (int i = 0; i < 20; i++) begin
            next_cyc();
        end
        check_eq("to sticky fault", 32'(fault), 32'd1);
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        #1;
        check_eq("to rst state", 32'(state), 32'd0);
        check_eq("to rst fault", 32'(fault), 32'd0);
        check_eq("to rst mem_req", 32'(mem_req), 32'd1);

        // Reset mid-SYSCALL aborts without retiring
        fetch_decode("pre", INop);
        check_eq("pre retired", retired, 32'd1);
        fetch_decode("sysr", ISys);
        next_cyc();
        check_eq("sysr syscall_req", 32'(syscall_req), 32'd1);
        reset = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        next_cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("sysr retired", retired, 32'd0);
        check_eq("sysr syscall_req after", 32'(syscall_req), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("sysr state", 32'(state), 32'd0);
        check_eq("sysr mem_req", 32'(mem_req), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
